// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/halt/step/reset sequencer for a debug-controlled core.
// Commands arrive as single-cycle pulses from the UART bridge and the step
// button. force_halt_in is a level override. All outputs are registered.
// Optional feature: define BREAKPOINT_EN to enable the PC breakpoint compare
// and the sticky bp_hit_out flag. When it is undefined, the breakpoint ports
// are still present but ignored, and bp_hit_out stays 0.
module cpu_run_controller #(
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        halt_in,
  input  logic        reset_in,
  input  logic        step_in,
  input  logic        force_halt_in,
  input  logic [7:0]  step_count_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] bp_addr_in,
  input  logic        bp_valid_in,
  output logic        cpu_step_out,
  output logic        cpu_rst_out,
  output logic [1:0]  state_out,
  output logic        bp_hit_out
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

  state_t     state_r;
  logic [7:0] cnt_r;        // shared down-counter for RESET and STEP length
  logic       cpu_step_r;
  logic       cpu_rst_r;
  logic       bp_hit_r;
  logic       run_first_r;  // high during the first cycle after entering RUN
  logic [7:0] step_load_s;
  logic       bp_match_s;
  logic       start_ok_s;

  // A step count of 0 still executes one instruction.
  assign step_load_s = (step_count_in == 8'd0) ? 8'd1 : step_count_in;

  // A start request is ignored while the halt override switch is on.
  assign start_ok_s = start_in & ~force_halt_in;

`ifdef BREAKPOINT_EN
  // The first RUN cycle is excluded so that restarting at the breakpoint PC works.
  assign bp_match_s = bp_valid_in & (pc_in == bp_addr_in) & ~run_first_r;
`else
  logic unused_bp_s;
  assign unused_bp_s = ^{pc_in, bp_addr_in, bp_valid_in, run_first_r};
  assign bp_match_s  = 1'b0;
`endif

  // Run-control FSM. The outputs are loaded together with the next state.
  always_ff @(posedge clk_in) begin
    if (rst_in || reset_in) begin
      state_r     <= ST_RESET;
      cnt_r       <= RST_LOAD;
      cpu_rst_r   <= 1'b1;
      cpu_step_r  <= 1'b0;
      bp_hit_r    <= 1'b0;
      run_first_r <= 1'b0;
    end else begin
      run_first_r <= 1'b0;
      case (state_r)
        ST_RESET: begin
          // Start, halt and step requests are not accepted while in reset.
          if (cnt_r <= 8'd1) begin
            state_r    <= ST_HALT;
            cpu_rst_r  <= 1'b0;
            cpu_step_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        ST_HALT: begin
          if (halt_in) begin
            state_r <= ST_HALT;
          end else if (start_ok_s) begin
            state_r     <= ST_RUN;
            cpu_step_r  <= 1'b1;
            bp_hit_r    <= 1'b0;
            run_first_r <= 1'b1;
          end else if (step_in) begin
            // A step is still allowed while the override switch is on.
            state_r    <= ST_STEP;
            cnt_r      <= step_load_s;
            cpu_step_r <= 1'b1;
          end else begin
            state_r <= ST_HALT;
          end
        end
        ST_RUN: begin
          if (halt_in || force_halt_in) begin
            state_r    <= ST_HALT;
            cpu_step_r <= 1'b0;
          end else if (bp_match_s) begin
            state_r    <= ST_HALT;
            cpu_step_r <= 1'b0;
            bp_hit_r   <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_STEP: begin
          if (halt_in) begin
            state_r    <= ST_HALT;
            cpu_step_r <= 1'b0;
          end else if (start_ok_s) begin
            // The remaining step count is discarded.
            state_r     <= ST_RUN;
            bp_hit_r    <= 1'b0;
            run_first_r <= 1'b1;
          end else if (cnt_r <= 8'd1) begin
            state_r    <= ST_HALT;
            cpu_step_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        default: begin
          state_r    <= ST_HALT;
          cpu_step_r <= 1'b0;
          cpu_rst_r  <= 1'b0;
        end
      endcase
    end
  end

  assign state_out    = state_r;
  assign cpu_step_out = cpu_step_r;
  assign cpu_rst_out  = cpu_rst_r;
  assign bp_hit_out   = bp_hit_r;

endmodule
